// File: rtl/video_vga_timing.sv
`default_nettype none
// video_vga_timing: VGA raster counters, composer strobes and palette-indexed RGB
// output stage. Rev 1.0. Sync and blank are delayed to stay aligned with the RGB path.
module video_vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int DATA_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        display_next_frame,
  output logic        display_next_line,
  output logic        display_next_pixel,
  output logic        display_current_field,
  input  logic [7:0]  display_data,
  output logic [7:0]  palette_addr,
  input  logic [11:0] palette_rgb,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hsync,
  output logic        vga_vsync
);

  // Sync/blank delay line; the output register adds the final stage so the
  // total delay is DATA_LAT+2, matching display_data -> palette_addr -> palette_rgb -> pins.
  localparam int DLY = DATA_LAT + 1;

  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]     h_cnt_q, h_cnt_d;
  logic [9:0]     v_cnt_q, v_cnt_d;
  logic           field_q;
  logic [7:0]     palette_addr_q;
  logic [11:0]    rgb_q;
  logic           hsync_q, vsync_q;
  logic [DLY-1:0] hs_sr_q, vs_sr_q, act_sr_q;
  logic           run, hs_raw, vs_raw;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!enable) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
    end else begin
      h_cnt_d = h_cnt_q + 10'd1;
    end
  end

  // Strobes are gated by rst_n so they read 0 while reset is held.
  always_comb begin
    run                = rst_n & enable;
    display_next_pixel = run && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    display_next_line  = run && (h_cnt_q == H_LAST);
    display_next_frame = display_next_line && (v_cnt_q == V_LAST);
    hs_raw             = !(run && (h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
    vs_raw             = !(run && (v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q        <= '0;
      v_cnt_q        <= '0;
      field_q        <= 1'b0;
      palette_addr_q <= '0;
      rgb_q          <= '0;
      hs_sr_q        <= '1;
      vs_sr_q        <= '1;
      act_sr_q       <= '0;
      hsync_q        <= 1'b1;
      vsync_q        <= 1'b1;
    end else begin
      h_cnt_q        <= h_cnt_d;
      v_cnt_q        <= v_cnt_d;
      if (display_next_frame) field_q <= ~field_q;
      palette_addr_q <= display_data;
      hs_sr_q        <= (hs_sr_q << 1) | DLY'(hs_raw);
      vs_sr_q        <= (vs_sr_q << 1) | DLY'(vs_raw);
      act_sr_q       <= (act_sr_q << 1) | DLY'(display_next_pixel);
      hsync_q        <= hs_sr_q[DLY-1];
      vsync_q        <= vs_sr_q[DLY-1];
      rgb_q          <= act_sr_q[DLY-1] ? palette_rgb : 12'h000;
    end
  end

  assign display_current_field = field_q;
  assign palette_addr          = palette_addr_q;
  assign vga_r                 = rgb_q[11:8];
  assign vga_g                 = rgb_q[7:4];
  assign vga_b                 = rgb_q[3:0];
  assign vga_hsync             = hsync_q;
  assign vga_vsync             = vsync_q;

endmodule
`default_nettype wire
